// File: rtl/spi_dbg_pkg.sv
// Shared definitions for the SPI debug register interface.
// Holds the register map, the command-word field positions, the STATUS
// bit positions and the frame FSM state encoding. It has no ports.
package spi_dbg_pkg;

    // Register map (10-bit register address space)
    localparam logic [9:0] ADDR_CHIP_VER = 10'h000;
    localparam logic [9:0] ADDR_CTRL     = 10'h001;
    localparam logic [9:0] ADDR_STATUS   = 10'h002;
    localparam logic [9:0] ADDR_ERRCNT   = 10'h003;
    localparam logic [9:0] BASE_RAM_ADDR = 10'h010;
    localparam logic [9:0] BASE_DATA     = 10'h020;

    // Command word: [15] rw (1 = read), [14] burst, [13:10] reserved, [9:0] addr
    localparam int CMD_RW_BIT    = 15;
    localparam int CMD_BURST_BIT = 14;
    localparam int CMD_ADDR_MSB  = 9;

    // STATUS register bits
    localparam int STAT_READY_BIT     = 0;
    localparam int STAT_ADDR_ERR_BIT  = 1;
    localparam int STAT_FRAME_ERR_BIT = 2;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        DONE
    } state_t;

    // Register addresses wrap 0x3FF -> 0x000 during bursts.
    function automatic logic [9:0] addr_inc(input logic [9:0] a);
        return a + 10'd1;
    endfunction

endpackage

// File: rtl/spi_os_engine.sv
// Oversampled SPI (mode 0) slave engine.
// Synchronises sclk/cs/mosi onto clk, derives edge strobes, counts bits,
// shifts command/data words and runs the frame FSM. Register accesses are
// presented on a simple single-cycle bus to the register bank.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   sclk, mosi, cs      raw SPI pins (cs active low)
//   miso                serial read data, 0 outside the read phase
//   busy                high while the FSM is not IDLE
//   frame_err           one-cycle pulse when cs rises mid-word
//   reg_addr            current register address
//   reg_we, reg_wdata   one-cycle write strobe and data
//   reg_re              one-cycle read strobe; reg_rdata is captured in that cycle
//   reg_rdata           read data from the register bank
module spi_os_engine
    import spi_dbg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs,
    output logic        miso,
    output logic        busy,
    output logic        frame_err,
    output logic [9:0]  reg_addr,
    output logic        reg_we,
    output logic [15:0] reg_wdata,
    output logic        reg_re,
    input  logic [15:0] reg_rdata
);

    // ---- pin stage: _p0/_p1 synchroniser, _p2 edge history ----
    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1, cs_p2;
    logic mosi_p0, mosi_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Cleared to 0 so a cs held low through reset never looks like a fall.
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b0;
            cs_p1   <= 1'b0;
            cs_p2   <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= cs;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    // ---- strobe stage: single-cycle edges consumed by the FSM ----
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign cs_fall   = ~cs_p1 & cs_p2;
    assign cs_rise   = cs_p1 & ~cs_p2;

    state_t      state;
    logic [3:0]  bitcnt;
    logic [15:0] shift_in;
    logic [15:0] shift_out;
    logic [15:0] wdata_q;
    logic [9:0]  addr_q;
    logic        burst_q;
    logic        busy_q;
    logic        frame_err_q;
    logic        we_q;
    logic        re_q;
    logic        miso_q;

    logic        in_frame;
    logic        last_bit;
    logic        shift_now;
    logic [15:0] word_in;

    assign in_frame  = (state == CMD) || (state == WDATA) || (state == RDATA);
    assign word_in   = {shift_in[14:0], mosi_p1};
    assign last_bit  = in_frame && sclk_rise && (bitcnt == 4'd15);
    // The fall right after a word boundary (bitcnt wrapped to 0) must not
    // shift: it precedes the first rise of the word and would drop the MSB.
    assign shift_now = (state == RDATA) && sclk_fall && (bitcnt != 4'd0) && !re_q;

    // ---- frame FSM ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bitcnt      <= 4'd0;
            addr_q      <= 10'd0;
            burst_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;

            if (in_frame && sclk_rise) begin
                bitcnt <= bitcnt + 4'd1;
            end

            if (cs_rise) begin
                state       <= IDLE;
                busy_q      <= 1'b0;
                miso_q      <= 1'b0;
                bitcnt      <= 4'd0;
                frame_err_q <= (bitcnt != 4'd0);
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state  <= CMD;
                            busy_q <= 1'b1;
                            bitcnt <= 4'd0;
                        end
                    end
                    CMD: begin
                        if (last_bit) begin
                            burst_q <= word_in[CMD_BURST_BIT];
                            addr_q  <= word_in[CMD_ADDR_MSB:0];
                            if (word_in[CMD_RW_BIT]) begin
                                state <= RDATA;
                                re_q  <= 1'b1;
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (last_bit) begin
                            we_q <= 1'b1;
                            if (!burst_q) begin
                                state <= DONE;
                            end
                        end
                        // Advance only after the write cycle has used the old address.
                        if (we_q && burst_q) begin
                            addr_q <= addr_inc(addr_q);
                        end
                    end
                    RDATA: begin
                        if (re_q) begin
                            miso_q <= reg_rdata[15];
                        end else if (shift_now) begin
                            miso_q <= shift_out[14];
                        end
                        // A burst prefetches the next word right away, so that
                        // address is read (and error-checked) even if the host
                        // ends the frame before clocking it out.
                        if (last_bit) begin
                            if (burst_q) begin
                                addr_q <= addr_inc(addr_q);
                                re_q   <= 1'b1;
                            end else begin
                                state  <= DONE;
                                miso_q <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        miso_q <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // ---- shift datapath ----
    always_ff @(posedge clk) begin
        if (in_frame && sclk_rise) begin
            shift_in <= word_in;
        end
        if (last_bit && (state == WDATA)) begin
            wdata_q <= word_in;
        end
        if ((state == RDATA) && re_q) begin
            shift_out <= reg_rdata;
        end else if (shift_now) begin
            shift_out <= {shift_out[14:0], 1'b0};
        end
    end

    assign miso      = miso_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign reg_addr  = addr_q;
    assign reg_we    = we_q;
    assign reg_wdata = wdata_q;
    assign reg_re    = re_q;

endmodule

// File: rtl/spi_debug_regif.sv
// SPI debug register interface for the multi-ADC capture path.
// The SPI pins are oversampled on clk_i by spi_os_engine; this top level
// holds the register bank (chip version, control, sticky status, error
// counter, per-channel RAM capture address and ADC data readback).
//
// Ports:
//   clk_i, rst_i        system clock (>= 8x SCLK), synchronous active-high reset
//   sclk_i, mosi_i, cs_i SPI mode 0 slave pins (cs active low)
//   miso_o              SPI read data, 0 outside the read phase
//   data_adc_i          per-channel ADC data, channel i at [i*DATA_W +: DATA_W]
//   error_cnt_i         external error counter (read-only register)
//   capture_ready_i     live capture-complete level
//   ram_addr_adc_o      per-channel RAM capture address, channel i at [i*16 +: 16]
//   capture_start_o     one-cycle capture start pulse
//   sel_adc_o           channel select
//   busy_o              frame in progress
//   frame_err_o         one-cycle pulse on an aborted frame
module spi_debug_regif
    import spi_dbg_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          DATA_W   = 16,
    parameter int          SEL_W    = 2,
    parameter logic [15:0] CHIP_VER = 16'h0200
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sclk_i,
    input  logic                     mosi_i,
    input  logic                     cs_i,
    output logic                     miso_o,
    input  logic [NUM_CH*DATA_W-1:0] data_adc_i,
    input  logic [15:0]              error_cnt_i,
    input  logic                     capture_ready_i,
    output logic [NUM_CH*16-1:0]     ram_addr_adc_o,
    output logic                     capture_start_o,
    output logic [SEL_W-1:0]         sel_adc_o,
    output logic                     busy_o,
    output logic                     frame_err_o
);

    logic [9:0]  reg_addr;
    logic        reg_we;
    logic [15:0] reg_wdata;
    logic        reg_re;
    logic [15:0] reg_rdata;
    logic        frame_err;

    spi_os_engine u_engine (
        .clk       (clk_i),
        .rst       (rst_i),
        .sclk      (sclk_i),
        .mosi      (mosi_i),
        .cs        (cs_i),
        .miso      (miso_o),
        .busy      (busy_o),
        .frame_err (frame_err),
        .reg_addr  (reg_addr),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata)
    );

    logic [15:0]      ram_addr_q [NUM_CH];
    logic [SEL_W-1:0] sel_q;
    logic             addr_err_q;
    logic             frame_err_st_q;
    logic             cap_start_q;

    // Read mux; rd_hit doubles as the "address is mapped" flag for writes.
    logic        rd_hit;
    logic [15:0] rd_val;

    always_comb begin
        rd_val = 16'h0000;
        rd_hit = 1'b0;
        case (reg_addr)
            ADDR_CHIP_VER: begin
                rd_hit = 1'b1;
                rd_val = CHIP_VER;
            end
            ADDR_CTRL: begin
                rd_hit = 1'b1;
                rd_val[SEL_W:1] = sel_q;
            end
            ADDR_STATUS: begin
                rd_hit = 1'b1;
                rd_val[STAT_READY_BIT]     = capture_ready_i;
                rd_val[STAT_ADDR_ERR_BIT]  = addr_err_q;
                rd_val[STAT_FRAME_ERR_BIT] = frame_err_st_q;
            end
            ADDR_ERRCNT: begin
                rd_hit = 1'b1;
                rd_val = error_cnt_i;
            end
            default: begin
            end
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (reg_addr == BASE_RAM_ADDR + 10'(i)) begin
                rd_hit = 1'b1;
                rd_val = ram_addr_q[i];
            end
            if (reg_addr == BASE_DATA + 10'(i)) begin
                rd_hit = 1'b1;
                rd_val = 16'(data_adc_i[i*DATA_W +: DATA_W]);
            end
        end
    end

    assign reg_rdata = rd_val;

    logic addr_err_set, addr_err_clr;
    logic frame_err_clr;
    logic status_we;

    assign status_we     = reg_we && (reg_addr == ADDR_STATUS);
    assign addr_err_set  = (reg_we || reg_re) && !rd_hit;
    assign addr_err_clr  = status_we && reg_wdata[STAT_ADDR_ERR_BIT];
    assign frame_err_clr = status_we && reg_wdata[STAT_FRAME_ERR_BIT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q          <= '0;
            addr_err_q     <= 1'b0;
            frame_err_st_q <= 1'b0;
            cap_start_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                ram_addr_q[i] <= 16'h0000;
            end
        end else begin
            cap_start_q <= reg_we && (reg_addr == ADDR_CTRL) && reg_wdata[0];
            if (reg_we && (reg_addr == ADDR_CTRL)) begin
                sel_q <= reg_wdata[SEL_W:1];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (reg_we && (reg_addr == BASE_RAM_ADDR + 10'(i))) begin
                    ram_addr_q[i] <= reg_wdata;
                end
            end
            // Sticky W1C bits: a set in the same cycle as a clear wins.
            addr_err_q     <= addr_err_set || (addr_err_q && !addr_err_clr);
            frame_err_st_q <= frame_err || (frame_err_st_q && !frame_err_clr);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ram_out
        assign ram_addr_adc_o[g*16 +: 16] = ram_addr_q[g];
    end

    assign sel_adc_o       = sel_q;
    assign capture_start_o = cap_start_q;
    assign frame_err_o     = frame_err;

endmodule

// File: tb/tb_spi_debug_regif.sv
// Self-checking bench for spi_debug_regif: a bit-banged SPI mode 0 master
// (SCLK = clk/16), a table of single-register accesses, and hand-written
// sequences for bursts, address wrap, aborted frames and mid-frame reset.
module tb_spi_debug_regif;

    localparam int HP = 8;  // SCLK half period in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        mosi;
    logic        cs;
    logic        miso;
    logic [63:0] adc_bus;
    logic [15:0] err_cnt;
    logic        cap_ready;
    logic [63:0] ram_addr;
    logic        cap_start;
    logic [1:0]  sel;
    logic        busy;
    logic        frame_err;

    spi_debug_regif dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .sclk_i          (sclk),
        .mosi_i          (mosi),
        .cs_i            (cs),
        .miso_o          (miso),
        .data_adc_i      (adc_bus),
        .error_cnt_i     (err_cnt),
        .capture_ready_i (cap_ready),
        .ram_addr_adc_o  (ram_addr),
        .capture_start_o (cap_start),
        .sel_adc_o       (sel),
        .busy_o          (busy),
        .frame_err_o     (frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cap_cnt = 0;
    int fe_cnt  = 0;

    always @(negedge clk) begin
        if (cap_start) cap_cnt++;
        if (frame_err) fe_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rd;
        logic [9:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shifts the top nbits of tx out MSB first; miso is sampled at each rise.
    task automatic spi_word(input logic [15:0] tx, input int nbits, output logic [15:0] rx);
        rx = 16'h0000;
        for (int b = 15; b > 15 - nbits; b--) begin
            mosi = tx[b];
            tick(HP);
            sclk = 1'b1;
            rx[b] = miso;
            tick(HP);
            sclk = 1'b0;
        end
    endtask

    task automatic rd_reg(input logic [9:0] a, output logic [15:0] d);
        logic [15:0] dummy;
        cs = 1'b0;
        tick(HP);
        spi_word({6'b100000, a}, 16, dummy);
        spi_word(16'h0000, 16, d);
        tick(HP);
        cs = 1'b1;
        tick(8);
    endtask

    task automatic wr_reg(input logic [9:0] a, input logic [15:0] d);
        logic [15:0] dummy;
        cs = 1'b0;
        tick(HP);
        spi_word({6'b000000, a}, 16, dummy);
        spi_word(d, 16, dummy);
        tick(HP);
        cs = 1'b1;
        tick(8);
    endtask

    initial begin
        logic [15:0] d, d2, dummy;
        int cap_before, fe_before;

        tbl[0] = '{1'b1, 10'h000, 16'h0000, 16'h0200};
        tbl[1] = '{1'b0, 10'h012, 16'hBEEF, 16'h0000};
        tbl[2] = '{1'b1, 10'h012, 16'h0000, 16'hBEEF};
        tbl[3] = '{1'b1, 10'h010, 16'h0000, 16'h0000};
        tbl[4] = '{1'b1, 10'h003, 16'h0000, 16'h5A5A};
        tbl[5] = '{1'b1, 10'h020, 16'h0000, 16'h1357};
        tbl[6] = '{1'b0, 10'h001, 16'h0004, 16'h0000};
        tbl[7] = '{1'b1, 10'h001, 16'h0000, 16'h0004};
        tbl[8] = '{1'b1, 10'h002, 16'h0000, 16'h0001};
        tbl[9] = '{1'b1, 10'h021, 16'h0000, 16'h0000};

        rst       = 1'b1;
        sclk      = 1'b0;
        mosi      = 1'b0;
        cs        = 1'b1;
        adc_bus   = {16'h0000, 16'h0000, 16'h0000, 16'h1357};
        err_cnt   = 16'h5A5A;
        cap_ready = 1'b1;
        tick(4);
        check("reset_outputs", {59'd0, miso, busy, frame_err, cap_start, sel == 2'b00} , 64'd1);
        check("reset_ram_addr", ram_addr, 64'd0);
        rst = 1'b0;
        tick(10);

        // First read of CHIP_VER with busy timing around cs rise
        cs = 1'b0;
        tick(HP);
        check("busy_in_frame", busy, 1);
        spi_word(16'h8000, 16, dummy);
        spi_word(16'h0000, 16, d);
        check("chip_ver_read", d, 16'h0200);
        tick(HP);
        cs = 1'b1;
        tick(2);
        check("busy_2clk_after_cs", busy, 1);
        tick(1);
        check("busy_3clk_after_cs", busy, 0);
        tick(8);

        // Table of single-register accesses
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rd) begin
                rd_reg(tbl[i].addr, d);
                check($sformatf("tbl%0d_read_%03h", i, tbl[i].addr), d, tbl[i].exp);
            end else begin
                wr_reg(tbl[i].addr, tbl[i].data);
            end
        end
        check("ram_addr_after_table", ram_addr, 64'h0000_BEEF_0000_0000);
        check("sel_after_table", sel, 2'b10);
        check("no_capture_yet", cap_cnt, 0);

        // Burst write across the wrap: 0x3FF (unmapped), 0x000 (RO), 0x001 (CTRL)
        cap_before = cap_cnt;
        cs = 1'b0;
        tick(HP);
        spi_word(16'h43FF, 16, dummy);
        spi_word(16'h1111, 16, dummy);
        spi_word(16'h2222, 16, dummy);
        spi_word(16'h3333, 16, dummy);
        tick(HP);
        cs = 1'b1;
        tick(8);
        check("burst_wr_sel", sel, 2'b01);
        check("burst_wr_capture_once", cap_cnt - cap_before, 1);
        check("burst_wr_ram_unchanged", ram_addr, 64'h0000_BEEF_0000_0000);
        rd_reg(10'h000, d);
        check("chip_ver_after_ro_write", d, 16'h0200);
        rd_reg(10'h002, d);
        check("status_addr_err_set", d, 16'h0003);
        wr_reg(10'h002, 16'h0002);
        rd_reg(10'h002, d);
        check("status_addr_err_cleared", d, 16'h0001);

        // Burst read of ch2/ch3 ADC data
        adc_bus = {16'h0ABC, 16'h0000, 16'h0000, 16'h1357};
        cs = 1'b0;
        tick(HP);
        spi_word(16'hC022, 16, dummy);
        spi_word(16'h0000, 16, d);
        spi_word(16'h0000, 16, d2);
        tick(HP);
        cs = 1'b1;
        tick(8);
        check("burst_rd_ch2", d, 16'h0000);
        check("burst_rd_ch3", d2, 16'h0ABC);

        // Burst read across the wrap: 0x3FF reads 0 and flags, then 0x000
        cs = 1'b0;
        tick(HP);
        spi_word(16'hC3FF, 16, dummy);
        spi_word(16'h0000, 16, d);
        spi_word(16'h0000, 16, d2);
        tick(HP);
        cs = 1'b1;
        tick(8);
        check("wrap_rd_unmapped", d, 16'h0000);
        check("wrap_rd_chip_ver", d2, 16'h0200);
        rd_reg(10'h002, d);
        check("status_after_unmapped_rd", d, 16'h0003);

        cap_ready = 1'b0;
        wr_reg(10'h002, 16'h0006);
        rd_reg(10'h002, d);
        check("status_all_clear", d, 16'h0000);

        // Aborted frame: cs rises after 9 bits of the data word
        fe_before = fe_cnt;
        cs = 1'b0;
        tick(HP);
        spi_word(16'h0010, 16, dummy);
        spi_word(16'hFFFF, 9, dummy);
        tick(HP);
        cs = 1'b1;
        tick(3);
        check("frame_err_pulse_high", frame_err, 1);
        tick(1);
        check("frame_err_pulse_low", frame_err, 0);
        tick(8);
        check("frame_err_single_pulse", fe_cnt - fe_before, 1);
        check("partial_word_no_write", ram_addr, 64'h0000_BEEF_0000_0000);
        rd_reg(10'h002, d);
        check("status_frame_err", d, 16'h0004);
        wr_reg(10'h002, 16'h0006);
        rd_reg(10'h002, d);
        check("status_frame_err_cleared", d, 16'h0000);

        // Reset in the middle of a write data word with cs held low
        fe_before = fe_cnt;
        cs = 1'b0;
        tick(HP);
        spi_word(16'h0011, 16, dummy);
        spi_word(16'hFFFF, 10, dummy);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("busy_after_mid_reset", busy, 0);
        check("ram_cleared_by_reset", ram_addr, 64'd0);
        spi_word(16'hFFFF, 6, dummy);
        spi_word(16'h0011, 16, dummy);
        spi_word(16'hABCD, 16, dummy);
        check("busy_ignores_sclk_cs_low", busy, 0);
        check("no_write_while_cs_held", ram_addr, 64'd0);
        tick(HP);
        cs = 1'b1;
        tick(8);
        check("no_frame_err_after_reset", fe_cnt - fe_before, 0);
        wr_reg(10'h011, 16'h5555);
        rd_reg(10'h011, d);
        check("recovered_rw", d, 16'h5555);
        check("recovered_ram_addr", ram_addr, 64'h0000_0000_5555_0000);
        check("capture_total", cap_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_debug_regif.md
Name: spi_debug_regif

Overview:
- Next-generation SPI debug interface for the multi-ADC capture path.
- Single clock domain: SPI pins are oversampled on clk_i, so no SPI-clocked register file exists.
- Integrates a parametrised register bank: NUM_CH ADC channels, each with a data readback and a RAM capture address, plus capture control and status.
- New over the previous generation: burst auto-increment, address-error and frame-error detection, W1C sticky status.

Parameters:
NUM_CH, 4, number of ADC channels (1..16)
DATA_W, 16, ADC data width per channel (1..16; zero-extended to 16 on readback)
SEL_W, 2, width of sel_adc_o (ceil(log2(NUM_CH)), min 1)
CHIP_VER, 16'h0200, value returned at address 0x000

Ports:
clk_i  in  1  system clock; must be >= 8x SCLK frequency
rst_i  in  1  synchronous, active-high reset
sclk_i  in  1  SPI clock, mode 0, asynchronous to clk_i
mosi_i  in  1  SPI data in
cs_i  in  1  SPI chip select, active low
miso_o  out  1  SPI data out; 0 when not in a read phase
data_adc_i  in  NUM_CH*DATA_W  per-channel ADC data, channel i at [i*DATA_W +: DATA_W]
error_cnt_i  in  16  external error counter, read-only
capture_ready_i  in  1  capture-complete level
ram_addr_adc_o  out  NUM_CH*16  per-channel RAM capture address
capture_start_o  out  1  single-cycle capture start pulse
sel_adc_o  out  SEL_W  channel select
busy_o  out  1  high while a frame is active (FSM not IDLE)
frame_err_o  out  1  single-cycle pulse on an aborted frame

Behaviour:
- Reset is synchronous and active-high, with one clock.
  - All outputs reset to 0.
  - ram_addr, sel_adc and sticky bits reset to 0; FSM resets to IDLE.
  - Synchronizer stages for sclk, cs and mosi reset to 0, so a cs_i held low through reset produces no falling edge. A new frame starts only after cs_i goes high and then low again.
- Input conditioning: 2-FF synchronizer per pin, plus one history FF.
  - sclk rise/fall and cs fall/rise are single-cycle strobes.
  - Pin-to-strobe latency is 3 clk.
- Frame format:
  - A command word is 16 bits, MSB first: [15] rw (1 = read), [14] burst, [13:10] reserved (ignored), [9:0] addr.
  - Data words of 16 bits follow.
  - mosi is sampled on the sclk-rise strobe; miso is updated on the sclk-fall strobe.
  - bitcnt is 4 bits, cleared on cs fall, and incremented on each rise strobe.
- FSM:
  - IDLE -> CMD on cs fall.
  - CMD: on the 16th rise, latch rw, burst and addr. If rw=1, go to RDATA; otherwise go to WDATA.
  - RDATA: in the clk after entering, load shift_q with rd_data(addr) and drive miso_o = shift_q[15].
    - On each fall strobe, shift left.
    - After the 16th rise with burst=1: addr <= addr+1, reload, and stay in RDATA.
    - With burst=0, go to DONE.
  - WDATA: on the 16th rise, issue a one-cycle internal write (wdata, addr) in the next clk.
    - With burst=1: addr <= addr+1 and stay in WDATA.
    - With burst=0, go to DONE.
  - DONE: ignore sclk and drive miso_o = 0.
  - Any state -> IDLE on cs rise. If bitcnt != 0 at that point, pulse frame_err_o and set STATUS.frame_err.
- Address arithmetic is 10-bit and wraps 0x3FF -> 0x000.
- Register map:
  - 0x000 CHIP_VER: RO.
  - 0x001 CTRL:
    - Writing bit0=1 pulses capture_start_o for 1 clk, 1 clk after the internal write. bit0 reads 0.
    - Bits [SEL_W:1] = sel_adc_o, RW.
  - 0x002 STATUS:
    - [0] capture_ready (live, RO).
    - [1] addr_err (sticky, W1C).
    - [2] frame_err (sticky, W1C).
    - If set and clear coincide in the same clk, set wins.
  - 0x003: error_cnt_i, RO.
  - 0x010+i, i<NUM_CH: ram_addr[i], RW, 16 bits.
  - 0x020+i, i<NUM_CH: data_adc[i] zero-extended, RO.
    - The read value is sampled at shift-register load, not continuously.
- Invalid access:
  - Reading an unmapped address returns 0x0000 and sets addr_err.
  - Writing an unmapped address is dropped and sets addr_err.
  - Writing an RO register is silently ignored.
- Partial last word (cs rise mid-word): no write is issued.

Decomposition:
- Package spi_dbg_pkg contains:
  - Address constants (ADDR_CHIP_VER, ADDR_CTRL, ADDR_STATUS, ADDR_ERRCNT, BASE_RAM_ADDR, BASE_DATA).
  - Command-field bit positions.
  - FSM state enum {IDLE, CMD, WDATA, RDATA, DONE}.
- Sub-module spi_os_engine: synchronizers, edge strobes, bitcnt, shift registers and FSM. It exposes a reg_addr/reg_we/reg_wdata/reg_rdata/reg_re port.
- The register bank lives in the top level.

Test Plan:
- Reset, then read 0x000 (cmd 0x8000) -> miso returns 0x0200; busy_o is high during the frame and low 3 clk after cs rises.
- Write 0x0012 = 0xBEEF, then read it back -> ram_addr_adc_o[47:32] = 0xBEEF; read data 0xBEEF; other channels stay 0.
- Burst write cmd 0x43FF with 3 data words 0x1111/0x2222/0x3333 -> writes to 0x3FF (addr_err set), 0x000 (ignored, RO), 0x001 (sel_adc_o = 2'b01; capture_start_o pulses exactly once since bit0=1).
- Drive data_adc_i ch3 = 0x0ABC, then burst read from 0x022 for 2 words -> 0x0000 (ch2), then 0x0ABC.
- Raise cs after 9 bits of a data word -> frame_err_o pulses 1 clk, STATUS reads 0x0004; write 0x0006 to STATUS -> reads 0x0000.
- Assert rst_i mid-WDATA with cs held low -> no write occurs, busy_o = 0; continued sclk is ignored until cs rises and falls again.
